// File: rtl/led_blinker.sv
// Free-running LED blinker: led toggles every PERIOD clocks, giving a 50% duty square wave.
// Optional status outputs (tick, blink_count) are built when LED_BLINKER_STATUS_EN is defined.
module led_blinker #(
    parameter int PERIOD = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
`ifdef LED_BLINKER_STATUS_EN
    output logic        tick,
    output logic [15:0] blink_count,
`endif
    output logic        led
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          led_q, led_d;
    logic          at_last;

    // Terminal compare is the only way back to zero, so cnt stays within 0..PERIOD-1.
    always_comb begin
        at_last = (cnt_q == LAST);
        cnt_d   = cnt_q + CW'(1);
        led_d   = led_q;
        if (at_last) begin
            cnt_d = '0;
            led_d = ~led_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            led_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
        end
    end

    assign led = led_q;

`ifdef LED_BLINKER_STATUS_EN
    logic        tick_q, tick_d;
    logic [15:0] blink_q, blink_d;

    // tick is registered alongside led, so it is high in exactly the cycle led shows its new value.
    always_comb begin
        tick_d  = at_last;
        blink_d = blink_q;
        if (at_last && !led_q) begin
            blink_d = blink_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q  <= 1'b0;
            blink_q <= 16'd0;
        end else begin
            tick_q  <= tick_d;
            blink_q <= blink_d;
        end
    end

    assign tick        = tick_q;
    assign blink_count = blink_q;
`endif

endmodule

// File: tb/tb_led_blinker.sv
// Self-checking bench for led_blinker: several instances with different PERIOD values,
// a vector table for PERIOD=5 and hand-written sequences for the other corner cases.
module tb_led_blinker;

  logic clk;
  logic r32, r1, r5, r3, r4;
  logic led32, led1, led5, led3, led4;
`ifdef LED_BLINKER_STATUS_EN
  logic        tick32, tick1, tick5, tick3, tick4;
  logic [15:0] bc32, bc1, bc5, bc3, bc4;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rst;
    logic exp_led;
  } vec_t;

  vec_t tbl[$];

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LED_BLINKER_STATUS_EN
  led_blinker #(.PERIOD(32)) u_p32 (.clk(clk), .reset(r32), .tick(tick32), .blink_count(bc32), .led(led32));
  led_blinker #(.PERIOD(1))  u_p1  (.clk(clk), .reset(r1),  .tick(tick1),  .blink_count(bc1),  .led(led1));
  led_blinker #(.PERIOD(5))  u_p5  (.clk(clk), .reset(r5),  .tick(tick5),  .blink_count(bc5),  .led(led5));
  led_blinker #(.PERIOD(3))  u_p3  (.clk(clk), .reset(r3),  .tick(tick3),  .blink_count(bc3),  .led(led3));
  led_blinker #(.PERIOD(4))  u_p4  (.clk(clk), .reset(r4),  .tick(tick4),  .blink_count(bc4),  .led(led4));
`else
  led_blinker #(.PERIOD(32)) u_p32 (.clk(clk), .reset(r32), .led(led32));
  led_blinker #(.PERIOD(1))  u_p1  (.clk(clk), .reset(r1),  .led(led1));
  led_blinker #(.PERIOD(5))  u_p5  (.clk(clk), .reset(r5),  .led(led5));
  led_blinker #(.PERIOD(3))  u_p3  (.clk(clk), .reset(r3),  .led(led3));
  led_blinker #(.PERIOD(4))  u_p4  (.clk(clk), .reset(r4),  .led(led4));
`endif

  // advance one rising edge and settle; inputs set after this apply at the next edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic rst, input logic exp_led, input int n);
    vec_t v;
    v.rst     = rst;
    v.exp_led = exp_led;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  initial begin
    int rises;
    int toggles;
    int first_rise;
    int ticks;
    logic prev;

    r32 = 1'b1; r1 = 1'b1; r5 = 1'b1; r3 = 1'b1; r4 = 1'b1;

    // PERIOD=5 vectors: {reset, led after the edge}
    add(1, 0, 3);
    add(0, 0, 4);   // edges 1..4
    add(0, 1, 5);   // rise on edge 5, held through edge 9
    add(0, 0, 5);   // fall on edge 10, cnt reaches 4 on edge 14
    add(1, 0, 1);   // reset on the terminal-count edge: no toggle
    add(0, 0, 4);
    add(0, 1, 5);   // rise a full period after release
    add(0, 0, 1);

    // 1: reset held 10 cycles, every instance stays dark
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("rst_led32", led32, 0);
      check("rst_led1",  led1,  0);
      check("rst_led5",  led5,  0);
      check("rst_led3",  led3,  0);
      check("rst_led4",  led4,  0);
`ifdef LED_BLINKER_STATUS_EN
      check("rst_tick4", tick4, 0);
      check("rst_bc4",   bc4,   0);
`endif
    end

    // 2: PERIOD=32 over 6400 cycles
    r32 = 1'b0;
    rises = 0;
    toggles = 0;
    first_rise = -1;
    prev = led32;
    for (int e = 1; e <= 6400; e++) begin
      cyc();
      if (led32 != prev) toggles++;
      if (led32 && !prev) begin
        rises++;
        if (first_rise < 0) first_rise = e;
      end
      prev = led32;
    end
    check("p32_first_rise", first_rise, 32);
    check("p32_rises", rises, 100);
    check("p32_toggles", toggles, 200);
    check("p32_final_led", led32, 0);
    r32 = 1'b1;

    // 3: PERIOD=1 toggles on every edge
    r1 = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      cyc();
      check("p1_alt", led1, e % 2);
    end
    r1 = 1'b1;
    cyc();
    check("p1_reset", led1, 0);

    // 4: table-driven PERIOD=5 including reset on the terminal-count edge
    for (int i = 0; i < tbl.size(); i++) begin
      r5 = tbl[i].rst;
      cyc();
      check($sformatf("p5_vec%0d", i), led5, tbl[i].exp_led);
    end
    r5 = 1'b1;

    // 5: PERIOD=3, reset pulsed while led is lit
    r3 = 1'b0;
    cyc(); check("p3_e1", led3, 0);
    cyc(); check("p3_e2", led3, 0);
    cyc(); check("p3_e3_rise", led3, 1);
    cyc(); check("p3_e4", led3, 1);
    r3 = 1'b1;
    cyc(); check("p3_rst_clears", led3, 0);
    r3 = 1'b0;
    cyc(); check("p3_r1", led3, 0);
    cyc(); check("p3_r2", led3, 0);
    cyc(); check("p3_r3_rise", led3, 1);
    cyc(); check("p3_r4", led3, 1);
    cyc(); check("p3_r5", led3, 1);
    cyc(); check("p3_r6_fall", led3, 0);

    // 6: PERIOD=4 over 80 cycles
    r4 = 1'b0;
    toggles = 0;
    rises = 0;
    ticks = 0;
    prev = led4;
    for (int e = 1; e <= 80; e++) begin
      cyc();
      if (led4 != prev) toggles++;
      if (led4 && !prev) rises++;
`ifdef LED_BLINKER_STATUS_EN
      if (tick4) ticks++;
      check("p4_tick_align", tick4, (led4 != prev) ? 1 : 0);
`endif
      prev = led4;
    end
    check("p4_toggles", toggles, 20);
    check("p4_rises", rises, 10);
`ifdef LED_BLINKER_STATUS_EN
    check("p4_ticks", ticks, 20);
    check("p4_blink_count", bc4, 10);
    r4 = 1'b1;
    cyc();
    check("p4_rst_bc", bc4, 0);
    check("p4_rst_tick", tick4, 0);
`else
    check("p4_ticks_unused", ticks, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
